// File: rtl/neuron_cfg_packet_tx_if.sv
// neuron_cfg_packet_tx_if: command handshake and byte-stream signals of the config packet transmitter
interface neuron_cfg_packet_tx_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_decay_mode;
    logic [2:0]  cmd_init_mode_adder;
    logic [1:0]  cmd_adder_model;
    logic        cmd_init_mode_acc;
    logic [9:0]  cmd_address;
    logic [31:0] cmd_value;
    logic [7:0]  data_out;
    logic        load_data;
    logic        busy;
    logic        done;
    modport master (
        output cmd_valid, cmd_op, cmd_decay_mode, cmd_init_mode_adder, cmd_adder_model,
               cmd_init_mode_acc, cmd_address, cmd_value,
        input  cmd_ready, data_out, load_data, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_decay_mode, cmd_init_mode_adder, cmd_adder_model,
               cmd_init_mode_acc, cmd_address, cmd_value,
        output cmd_ready, data_out, load_data, busy, done
    );
endinterface

// File: rtl/neuron_cfg_packet_tx.sv
// neuron_cfg_packet_tx: serialises one config command into strobed protocol bytes with a fixed inter-byte gap
module neuron_cfg_packet_tx #(
    parameter int         BYTE_GAP       = 2,
    parameter logic [7:0] OP_SET_CTRL    = 8'h01,
    parameter logic [7:0] OP_ADDR_WEIGHT = 8'h02,
    parameter logic [7:0] OP_WEIGHT      = 8'h03,
    parameter logic [7:0] OP_END         = 8'hFF
) (
    input logic                  clk,
    input logic                  rst,
    neuron_cfg_packet_tx_if.slave bus
);
    localparam int GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    typedef enum logic [1:0] {IDLE, STROBE, GAP, DONE} state_e;
    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  op_q;
    logic [7:0]  c0_q;
    logic        acc_q;
    logic [9:0]  addr_q;
    logic [31:0] value_q;
    logic        accept;
    logic [3:0]  last_idx;
    logic [1:0]  vsel;
    logic [7:0]  op_byte, cur_byte;
    assign accept = bus.cmd_valid && bus.cmd_ready;
    always_comb begin
        last_idx = op_q == 2'd0 ? 4'd2 : op_q == 2'd1 ? 4'd8 : op_q == 2'd2 ? 4'd6 : 4'd0;
        op_byte  = op_q == 2'd0 ? OP_SET_CTRL : op_q == 2'd1 ? OP_ADDR_WEIGHT :
                   op_q == 2'd2 ? OP_WEIGHT : OP_END;
        // value bytes start at index 5 after the address bytes, else at index 3
        vsel     = idx_q[1:0] - (op_q == 2'd1 ? 2'd1 : 2'd3);
        cur_byte = idx_q == 4'd0 ? op_byte :
                   idx_q == 4'd1 ? c0_q :
                   idx_q == 4'd2 ? {7'b0, acc_q} :
                   (op_q == 2'd1 && idx_q == 4'd3) ? addr_q[7:0] :
                   (op_q == 2'd1 && idx_q == 4'd4) ? {6'b0, addr_q[9:8]} :
                   value_q[{vsel, 3'b000} +: 8];
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = STROBE;
                    idx_d   = '0;
                end
            end
            STROBE: begin
                state_d = GAP;
                gap_d   = '0;
                data_d  = cur_byte;
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(BYTE_GAP - 1)) begin
                    state_d = idx_q == last_idx ? DONE : STROBE;
                    idx_d   = idx_q == last_idx ? idx_q : idx_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            op_q    <= '0;
            c0_q    <= '0;
            acc_q   <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            if (accept) begin
                op_q    <= bus.cmd_op;
                c0_q    <= {bus.cmd_adder_model, bus.cmd_init_mode_adder, bus.cmd_decay_mode};
                acc_q   <= bus.cmd_init_mode_acc;
                addr_q  <= bus.cmd_address;
                value_q <= bus.cmd_value;
            end
        end
    end
    // the strobe cycle shows the new byte directly; data_q carries it through the gap and beyond
    assign bus.data_out  = state_q == STROBE ? cur_byte : data_q;
    assign bus.load_data = state_q == STROBE;
    assign bus.busy      = state_q == STROBE || state_q == GAP;
    assign bus.done      = state_q == DONE;
    assign bus.cmd_ready = state_q == IDLE && !rst;
endmodule

// File: tb/tb_neuron_cfg_packet_tx.sv
// tb_neuron_cfg_packet_tx: directed packets with hand-computed bytes and strobe timing
module tb_neuron_cfg_packet_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc[$];
    int sc[$];
    int dc[$];
    logic [7:0] sb[$];
    int busy_n = 0;
    int wide = 0;
    int rdy_bad = 0;
    logic prev_load = 1'b0;
    neuron_cfg_packet_tx_if bif();
    neuron_cfg_packet_tx #(.BYTE_GAP(2)) dut (.clk(clk), .rst(rst), .bus(bif.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bif.cmd_valid && bif.cmd_ready && !rst) acc.push_back(cyc);
        if (bif.load_data) begin
            sb.push_back(bif.data_out);
            sc.push_back(cyc);
            if (prev_load) wide++;
        end
        prev_load = bif.load_data;
        if (bif.done) dc.push_back(cyc);
        if (bif.busy) busy_n++;
        if ((bif.busy || bif.done) && bif.cmd_ready) rdy_bad++;
    end
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic clear();
        acc.delete();
        sc.delete();
        dc.delete();
        sb.delete();
        busy_n = 0;
        wide = 0;
        rdy_bad = 0;
    endtask
    task automatic drive(logic [1:0] op, logic [2:0] dm, logic [2:0] ia, logic [1:0] am,
                         logic ac, logic [9:0] addr, logic [31:0] val, bit hold);
        int t = 0;
        @(posedge clk); #1;
        bif.cmd_op = op;
        bif.cmd_decay_mode = dm;
        bif.cmd_init_mode_adder = ia;
        bif.cmd_adder_model = am;
        bif.cmd_init_mode_acc = ac;
        bif.cmd_address = addr;
        bif.cmd_value = val;
        bif.cmd_valid = 1'b1;
        while (!bif.cmd_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("accept_timeout", 32'(t), 32'd0);
        @(posedge clk); #1;
        if (!hold) bif.cmd_valid = 1'b0;
    endtask
    task automatic wait_done(int n);
        int t = 0;
        while (dc.size() < n && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check("done_seen", 32'(dc.size()), 32'(n));
    endtask
    task automatic check_pkt(string tag, int n, logic [7:0] e [9]);
        check({tag, "_acc"}, 32'(acc.size()), 32'd1);
        check({tag, "_nbytes"}, 32'(sb.size()), 32'(n));
        for (int k = 0; k < n && k < sb.size(); k++) begin
            check($sformatf("%s_b%0d", tag, k), 32'(sb[k]), 32'(e[k]));
            if (acc.size() > 0) check($sformatf("%s_t%0d", tag, k), 32'(sc[k] - acc[0]), 32'(1 + k * 3));
        end
        if (acc.size() > 0 && dc.size() > 0) check({tag, "_done_t"}, 32'(dc[0] - acc[0]), 32'(1 + n * 3));
        check({tag, "_wide"}, 32'(wide), 32'd0);
        check({tag, "_rdy"}, 32'(rdy_bad), 32'd0);
    endtask
    initial begin
        logic [7:0] e [9];
        int t;
        bif.cmd_valid = 1'b0;
        bif.cmd_op = '0;
        bif.cmd_decay_mode = '0;
        bif.cmd_init_mode_adder = '0;
        bif.cmd_adder_model = '0;
        bif.cmd_init_mode_acc = 1'b0;
        bif.cmd_address = '0;
        bif.cmd_value = '0;
        @(negedge clk); #1;
        check("rst_ready", 32'(bif.cmd_ready), 32'd0);
        check("rst_load", 32'(bif.load_data), 32'd0);
        check("rst_data", 32'(bif.data_out), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_done", 32'(bif.done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("ready_after_rst", 32'(bif.cmd_ready), 32'd1);
        clear();
        drive(2'd0, 3'b101, 3'b010, 2'b11, 1'b1, 10'h0, 32'h0, 1'b0);
        wait_done(1);
        e = '{8'h01, 8'hD5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_pkt("set_ctrl", 3, e);
        check("hold_after_done", 32'(bif.data_out), 32'h01);
        clear();
        drive(2'd1, 3'b000, 3'b000, 2'b00, 1'b0, 10'h2A5, 32'hDEADBEEF, 1'b0);
        wait_done(1);
        e = '{8'h02, 8'h00, 8'h00, 8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        check_pkt("addr_w", 9, e);
        clear();
        drive(2'd2, 3'b001, 3'b100, 2'b01, 1'b0, 10'h3FF, 32'h12345678, 1'b0);
        bif.cmd_value = 32'hFFFFFFFF;
        bif.cmd_op = 2'd3;
        bif.cmd_decay_mode = 3'b111;
        wait_done(1);
        @(negedge clk); #1;
        check("ready_after_done", 32'(bif.cmd_ready), 32'd1);
        e = '{8'h03, 8'h61, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00};
        check_pkt("weight", 7, e);
        clear();
        drive(2'd3, 3'b000, 3'b000, 2'b00, 1'b0, 10'h0, 32'h0, 1'b0);
        wait_done(1);
        e = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_pkt("end", 1, e);
        check("end_busy_cycles", 32'(busy_n), 32'd3);
        clear();
        drive(2'd1, 3'b000, 3'b000, 2'b00, 1'b0, 10'h2A5, 32'hDEADBEEF, 1'b0);
        t = 0;
        while (sb.size() < 4 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        check("abort_reached_b4", 32'(sb.size()), 32'd4);
        rst = 1'b1;
        @(negedge clk); #1;
        check("abort_load", 32'(bif.load_data), 32'd0);
        check("abort_data", 32'(bif.data_out), 32'd0);
        check("abort_busy", 32'(bif.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("abort_no_done", 32'(dc.size()), 32'd0);
        check("abort_no_resume", 32'(sb.size()), 32'd4);
        clear();
        drive(2'd3, 3'b000, 3'b000, 2'b00, 1'b0, 10'h0, 32'h0, 1'b0);
        wait_done(1);
        check_pkt("end_after_abort", 1, e);
        clear();
        drive(2'd2, 3'b111, 3'b000, 2'b10, 1'b1, 10'h0, 32'h12345678, 1'b1);
        bif.cmd_op = 2'd3;
        bif.cmd_value = 32'h0;
        t = 0;
        while (acc.size() < 2 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        bif.cmd_valid = 1'b0;
        wait_done(2);
        check("q_acc", 32'(acc.size()), 32'd2);
        check("q_nbytes", 32'(sb.size()), 32'd8);
        if (acc.size() == 2 && dc.size() == 2) begin
            check("q_second_accept", 32'(acc[1] - dc[0]), 32'd1);
            check("q_end_done_t", 32'(dc[1] - acc[1]), 32'd4);
        end
        e = '{8'h03, 8'h87, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'h00};
        for (int k = 0; k < 8 && k < sb.size(); k++) check($sformatf("q_b%0d", k), 32'(sb[k]), 32'(e[k]));
        check("q_wide", 32'(wide), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
